memory_stage: RTL and testbench

- Pipeline MEM stage. Consumes the EX/MEM-registered ALU result (effective address) and store data produced by the execute stage.
- Drives a req/gnt/rvalid data-memory port with byte enables and store-data lane replication.
- Aligns and sign/zero-extends load data for MEM/WB.
- Raises a stall while an access is outstanding, so upstream registers hold.

---
 rtl/memory_stage.sv | 178 +++++++++++++++++
 tb/tb_memory_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage -- pipeline MEM stage of an RV32 core.
//
// Turns the EX/MEM effective address and forwarded store data into a
// req/gnt/rvalid data-memory access. Byte enables and store-lane replication
// are derived combinationally from the held MEM inputs. Load data is aligned
// and sign/zero-extended for MEM/WB. A stall is raised while an access is
// outstanding so that upstream registers hold.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   MEM_valid_i         valid instruction in MEM
//   MEM_MemRead_i       load (wins when MemWrite is also set)
//   MEM_MemWrite_i      store
//   MEM_funct3_i        access width / signedness
//   MEM_alu_result_i    effective address
//   MEM_wr_data_i       store data
//   dmem_req_o          access request
//   dmem_we_o           write enable
//   dmem_addr_o         word-aligned address
//   dmem_be_o           byte enables
//   dmem_wdata_o        lane-replicated store data
//   dmem_gnt_i          request accepted this cycle
//   dmem_rvalid_i       read data valid
//   dmem_rdata_i        read word
//   MEM_rd_data_o       extended load result (live in rvalid cycle, else held)
//   MEM_stall_o         hold IF/ID/EX/MEM registers
//   MEM_misaligned_o    access suppressed (misaligned or illegal width)
module memory_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MEM_valid_i,
    input  logic                  MEM_MemRead_i,
    input  logic                  MEM_MemWrite_i,
    input  logic [2:0]            MEM_funct3_i,
    input  logic [ADDR_WIDTH-1:0] MEM_alu_result_i,
    input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic [DATA_WIDTH-1:0] MEM_rd_data_o,
    output logic                  MEM_stall_o,
    output logic                  MEM_misaligned_o
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WAIT_GNT    = 2'd1;
    localparam logic [1:0] WAIT_RVALID = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_load;
    logic [DATA_WIDTH-1:0] load_word;

    logic       mem_op, is_load, is_store, illegal, misalign, access;
    logic [1:0] off;
    logic [3:0] be_raw;

    // Align the addressed lane down to bit 0, then extend per funct3.
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [2:0]            f3,
        input logic [1:0]            lane,
        input logic [DATA_WIDTH-1:0] word
    );
        logic [DATA_WIDTH-1:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            3'b100:  return {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            3'b001:  return {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            3'b101:  return {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // Access decode (combinational from the held MEM inputs)
    assign off      = MEM_alu_result_i[1:0];
    assign mem_op   = MEM_valid_i & (MEM_MemRead_i | MEM_MemWrite_i);
    assign is_load  = MEM_MemRead_i;
    assign is_store = MEM_MemWrite_i & ~MEM_MemRead_i;

    // funct3[2] only means "unsigned" for loads, so stores accept 000..010.
    assign illegal  = is_load ? ((MEM_funct3_i == 3'b011) || (MEM_funct3_i[2:1] == 2'b11))
                              : (MEM_funct3_i > 3'b010);
    assign misalign = ((MEM_funct3_i[1:0] == 2'b01) && off[0]) ||
                      ((MEM_funct3_i[1:0] == 2'b10) && (off != 2'b00));

    assign MEM_misaligned_o = mem_op & (illegal | misalign);
    assign access           = mem_op & ~MEM_misaligned_o;

    always_comb begin
        case (MEM_funct3_i[1:0])
            2'b00:   be_raw = 4'b0001 << off;
            2'b01:   be_raw = 4'b0011 << {off[1], 1'b0};
            default: be_raw = 4'b1111;
        endcase
    end

    assign dmem_addr_o = {MEM_alu_result_i[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_we_o   = access & is_store;
    assign dmem_be_o   = access ? be_raw : 4'b0000;

    always_comb begin
        case (MEM_funct3_i[1:0])
            2'b00:   dmem_wdata_o = {4{MEM_wr_data_i[7:0]}};
            2'b01:   dmem_wdata_o = {2{MEM_wr_data_i[15:0]}};
            default: dmem_wdata_o = MEM_wr_data_i;
        endcase
    end

    assign load_word = load_extend(MEM_funct3_i, off, dmem_rdata_i);

    // Handshake FSM
    always_comb begin
        state_d       = state_q;
        dmem_req_o    = 1'b0;
        MEM_stall_o   = 1'b0;
        MEM_rd_data_o = hold_q;
        hold_load     = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_req_o = access;
                if (access) begin
                    if (dmem_gnt_i) begin
                        // Stores retire in the grant cycle; loads wait for data.
                        if (is_load) begin
                            state_d     = WAIT_RVALID;
                            MEM_stall_o = 1'b1;
                        end
                    end else begin
                        state_d     = WAIT_GNT;
                        MEM_stall_o = 1'b1;
                    end
                end
            end
            WAIT_GNT: begin
                dmem_req_o  = 1'b1;
                MEM_stall_o = 1'b1;
                if (dmem_gnt_i) begin
                    if (is_load) begin
                        state_d = WAIT_RVALID;
                    end else begin
                        state_d     = IDLE;
                        MEM_stall_o = 1'b0;
                    end
                end
            end
            WAIT_RVALID: begin
                MEM_stall_o = ~dmem_rvalid_i;
                if (dmem_rvalid_i) begin
                    MEM_rd_data_o = load_word;
                    hold_load     = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and load-hold registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (hold_load) hold_q <= load_word;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage -- directed self-checking bench for memory_stage.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, mrd, mwr;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    logic        req, we;
    logic [31:0] daddr, wdata;
    logic [3:0]  be;
    logic        gnt, rvalid;
    logic [31:0] rdata, rd_data;
    logic        stall, misal;

    int tests = 0;
    int fails = 0;

    memory_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_valid_i(valid), .MEM_MemRead_i(mrd), .MEM_MemWrite_i(mwr),
        .MEM_funct3_i(f3), .MEM_alu_result_i(addr), .MEM_wr_data_i(wd),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(daddr),
        .dmem_be_o(be), .dmem_wdata_o(wdata),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .MEM_rd_data_o(rd_data), .MEM_stall_o(stall), .MEM_misaligned_o(misal)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 0; mrd = 0; mwr = 0; f3 = 3'b000; addr = 0; wd = 0;
        gnt = 0; rvalid = 0; rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #1;
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", req); end
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", we); end
        tests++; if (be !== 4'b0000) begin fails++; $display("FAIL reset_be got %b want 0000", be); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        tests++; if (misal !== 1'b0) begin fails++; $display("FAIL reset_misal got %b want 0", misal); end
        cyc(); cyc();
        rst_n = 1;
        cyc();
    endtask

    task automatic test_sw_same_cycle();
        valid = 1; mwr = 1; f3 = 3'b010; addr = 32'h100; wd = 32'hDEADBEEF; gnt = 1;
        #1;
        tests++; if (req !== 1'b1) begin fails++; $display("FAIL sw_req got %b want 1", req); end
        tests++; if (we !== 1'b1) begin fails++; $display("FAIL sw_we got %b want 1", we); end
        tests++; if (be !== 4'b1111) begin fails++; $display("FAIL sw_be got %b want 1111", be); end
        tests++; if (daddr !== 32'h100) begin fails++; $display("FAIL sw_addr got %h want 00000100", daddr); end
        tests++; if (wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_wdata got %h want deadbeef", wdata); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sw_stall got %b want 0", stall); end
        cyc();
        idle_inputs();
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sw_after_stall got %b want 0", stall); end
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL sw_after_req got %b want 0", req); end
        cyc();
    endtask

    task automatic test_sb_delayed_gnt();
        valid = 1; mwr = 1; f3 = 3'b000; addr = 32'h103; wd = 32'h000000A5; gnt = 0;
        #1;
        tests++; if (be !== 4'b1000) begin fails++; $display("FAIL sb_be got %b want 1000", be); end
        tests++; if (wdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL sb_wdata got %h want a5a5a5a5", wdata); end
        tests++; if (daddr !== 32'h100) begin fails++; $display("FAIL sb_addr got %h want 00000100", daddr); end
        for (int c = 0; c < 2; c++) begin
            tests++; if (req !== 1'b1) begin fails++; $display("FAIL sb_wait_req c%0d got %b want 1", c, req); end
            tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sb_wait_stall c%0d got %b want 1", c, stall); end
            cyc();
        end
        gnt = 1;
        #1;
        tests++; if (req !== 1'b1) begin fails++; $display("FAIL sb_gnt_req got %b want 1", req); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_gnt_stall got %b want 0", stall); end
        cyc();
        idle_inputs();
        #1;
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL sb_done_req got %b want 0", req); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_done_stall got %b want 0", stall); end
        cyc();
    endtask

    // Load with gnt in the request cycle and rvalid one cycle later.
    task automatic run_load(input string nm, input logic [2:0] fn, input logic [31:0] a,
                            input logic [31:0] rd, input logic [3:0] exp_be,
                            input logic [31:0] exp);
        valid = 1; mrd = 1; f3 = fn; addr = a; gnt = 1;
        #1;
        tests++; if (req !== 1'b1 || we !== 1'b0) begin fails++; $display("FAIL %s_req got req=%b we=%b want 1/0", nm, req, we); end
        tests++; if (be !== exp_be) begin fails++; $display("FAIL %s_be got %b want %b", nm, be, exp_be); end
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL %s_stall0 got %b want 1", nm, stall); end
        cyc();
        gnt = 0; rvalid = 1; rdata = rd;
        #1;
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL %s_rv_req got %b want 0", nm, req); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL %s_rv_stall got %b want 0", nm, stall); end
        tests++; if (rd_data !== exp) begin fails++; $display("FAIL %s_rv_data got %h want %h", nm, rd_data, exp); end
        cyc();
        idle_inputs();
        #1;
        tests++; if (rd_data !== exp) begin fails++; $display("FAIL %s_hold got %h want %h", nm, rd_data, exp); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL %s_idle_stall got %b want 0", nm, stall); end
        cyc();
    endtask

    task automatic test_lb_lbu();
        run_load("lb",  3'b000, 32'h102, 32'h12F45678, 4'b0100, 32'hFFFFFFF4);
        run_load("lbu", 3'b100, 32'h102, 32'h12F45678, 4'b0100, 32'h000000F4);
    endtask

    task automatic test_lh_lhu();
        run_load("lh",  3'b001, 32'h102, 32'h80010000, 4'b1100, 32'hFFFF8001);
        run_load("lhu", 3'b101, 32'h102, 32'h80010000, 4'b1100, 32'h00008001);
    endtask

    task automatic test_misaligned();
        logic [2:0] fns [3]  = '{3'b001, 3'b011, 3'b100};
        logic       lds [3]  = '{1'b1, 1'b1, 1'b0};
        logic [31:0] as [3]  = '{32'h101, 32'h100, 32'h100};
        for (int k = 0; k < 3; k++) begin
            valid = 1; mrd = lds[k]; mwr = ~lds[k]; f3 = fns[k]; addr = as[k]; gnt = 1;
            #1;
            tests++; if (misal !== 1'b1) begin fails++; $display("FAIL misal%0d_flag got %b want 1", k, misal); end
            tests++; if (req !== 1'b0) begin fails++; $display("FAIL misal%0d_req got %b want 0", k, req); end
            tests++; if (stall !== 1'b0) begin fails++; $display("FAIL misal%0d_stall got %b want 0", k, stall); end
            tests++; if (be !== 4'b0000 || we !== 1'b0) begin fails++; $display("FAIL misal%0d_be got be=%b we=%b want 0000/0", k, be, we); end
            cyc();
        end
        idle_inputs();
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL misal_after_stall got %b want 0", stall); end
        cyc();
    endtask

    task automatic test_reset_mid_load();
        valid = 1; mrd = 1; f3 = 3'b010; addr = 32'h300; gnt = 1;
        cyc();
        gnt = 0;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rst_mid_wait_stall got %b want 1", stall); end
        rst_n = 0;
        idle_inputs();
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_mid_stall got %b want 0", stall); end
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL rst_mid_req got %b want 0", req); end
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rst_mid_data got %h want 0", rd_data); end
        cyc();
        rst_n = 1;
        cyc();
        rvalid = 1; rdata = 32'hCAFEBABE;
        #1;
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rst_late_rvalid_data got %h want 0", rd_data); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_late_rvalid_stall got %b want 0", stall); end
        cyc();
        idle_inputs();
        #1;
        tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rst_after_data got %h want 0", rd_data); end
        // A same-cycle-grant store proves the FSM sits in IDLE.
        valid = 1; mwr = 1; f3 = 3'b010; addr = 32'h10; wd = 32'h1; gnt = 1;
        #1;
        tests++; if (stall !== 1'b0 || req !== 1'b1) begin fails++; $display("FAIL rst_idle_store got stall=%b req=%b want 0/1", stall, req); end
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic test_back_to_back();
        valid = 1; mrd = 1; f3 = 3'b010; addr = 32'h200; gnt = 1;
        #1;
        tests++; if (req !== 1'b1 || be !== 4'b1111) begin fails++; $display("FAIL b2b_lw_req got req=%b be=%b want 1/1111", req, be); end
        for (int c = 0; c < 3; c++) begin
            tests++; if (stall !== 1'b1) begin fails++; $display("FAIL b2b_lw_stall c%0d got %b want 1", c, stall); end
            cyc();
        end
        rvalid = 1; rdata = 32'h13579BDF;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_rv_stall got %b want 0", stall); end
        tests++; if (rd_data !== 32'h13579BDF) begin fails++; $display("FAIL b2b_rv_data got %h want 13579bdf", rd_data); end
        cyc();
        rvalid = 0; mrd = 0; mwr = 1; addr = 32'h204; wd = 32'h24681ACE;
        #1;
        tests++; if (req !== 1'b1 || we !== 1'b1) begin fails++; $display("FAIL b2b_sw_req got req=%b we=%b want 1/1", req, we); end
        tests++; if (daddr !== 32'h204) begin fails++; $display("FAIL b2b_sw_addr got %h want 00000204", daddr); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_sw_stall got %b want 0", stall); end
        tests++; if (rd_data !== 32'h13579BDF) begin fails++; $display("FAIL b2b_hold got %h want 13579bdf", rd_data); end
        cyc();
        idle_inputs();
        cyc();
    endtask

    initial begin
        test_reset();
        test_sw_same_cycle();
        test_sb_delayed_gnt();
        test_lb_lbu();
        test_lh_lhu();
        test_misaligned();
        test_reset_mid_load();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
